// File: rtl/maze_pkg.sv
// Shared state encoding, direction codes and default steering offsets for the
// MazeRunner travel-plan sequencer.
package maze_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FOLLOW = 3'd1,
      VEER   = 3'd2,
      TURN   = 3'd3,
      STOP   = 3'd4
   } state_e;

   localparam logic [1:0] DIR_STOP = 2'b00;
   localparam logic [1:0] DIR_RGHT = 2'b01;
   localparam logic [1:0] DIR_LFT  = 2'b10;
   localparam logic [1:0] DIR_TURN = 2'b11;

   localparam logic signed [11:0] VEER_OFF_DFLT = 12'sd400;
   localparam logic signed [11:0] TURN_OFF_DFLT = 12'sd1024;

   localparam int DWELL_W = 20;

endpackage

// File: rtl/line_dbnc.sv
// Run-length qualifier for the IR line sensor: gap_qual after GAP_CYC consecutive
// absent samples, line_qual after LINE_CYC consecutive present samples; no backpressure.
module line_dbnc #(
   parameter int GAP_CYC  = 1024,
   parameter int LINE_CYC = 256
) (
   input  logic clk,
   input  logic rst_n,
   input  logic line_present,
   output logic gap_qual,
   output logic line_qual
);

   localparam int               MAX_CYC  = (GAP_CYC > LINE_CYC) ? GAP_CYC : LINE_CYC;
   localparam int               CNT_W    = $clog2(MAX_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MAX_CYC);
   localparam logic [CNT_W-1:0] GAP_THR  = CNT_W'(GAP_CYC);
   localparam logic [CNT_W-1:0] LINE_THR = CNT_W'(LINE_CYC);

   logic [CNT_W-1:0] absent_q, absent_d;
   logic [CNT_W-1:0] present_q, present_d;

   // Each run counter restarts the moment the opposite level is sampled.
   always_comb begin
      absent_d  = '0;
      present_d = '0;
      if (line_present) begin
         present_d = (present_q == CNT_SAT) ? present_q : present_q + 1'b1;
      end else begin
         absent_d = (absent_q == CNT_SAT) ? absent_q : absent_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         absent_q  <= '0;
         present_q <= '0;
      end else begin
         absent_q  <= absent_d;
         present_q <= present_d;
      end
   end

   assign gap_qual  = (absent_q >= GAP_THR);
   assign line_qual = (present_q >= LINE_THR);

endmodule

// File: rtl/maze_plan_ctrl.sv
// Travel-plan sequencer: pops one 2-bit code per line gap and steers, spins or stops the robot.
// Outputs are registered off the state register (one cycle behind transitions); cmd_rdy waits outside IDLE/STOP.
module maze_plan_ctrl
   import maze_pkg::*;
#(
   parameter int                 GAP_CYC      = 1024,
   parameter int                 LINE_CYC     = 256,
   parameter int                 VEER_MIN_CYC = 65536,
   parameter int                 TURN_MIN_CYC = 262144,
   parameter logic signed [11:0] VEER_OFF     = VEER_OFF_DFLT,
   parameter logic signed [11:0] TURN_OFF     = TURN_OFF_DFLT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [15:0]        cmd,
   input  logic               cmd_rdy,
   output logic               clr_cmd_rdy,
   input  logic               line_present,
   input  logic               BMPL_n,
   input  logic               BMPR_n,
   output logic               go,
   output logic signed [11:0] err_offset,
   output logic               buzz_en,
   output logic [2:0]         state_dbg
);

   localparam logic [DWELL_W-1:0] VEER_THR = DWELL_W'(VEER_MIN_CYC);
   localparam logic [DWELL_W-1:0] TURN_THR = DWELL_W'(TURN_MIN_CYC);

   state_e                  state_q, state_d;
   logic [15:0]             plan_q, plan_d;
   logic signed [11:0]      off_q, off_d;
   logic [DWELL_W-1:0]      dwell_q, dwell_d;
   logic                    go_q, go_d;
   logic signed [11:0]      err_q, err_d;
   logic                    buzz_q, buzz_d;
   logic                    clr_q, clr_d;
   logic [2:0]              dbg_q;
   logic                    gap_qual, line_qual;
   logic                    bump;

   line_dbnc #(
      .GAP_CYC  (GAP_CYC),
      .LINE_CYC (LINE_CYC)
   ) u_line_dbnc (
      .clk          (clk),
      .rst_n        (rst_n),
      .line_present (line_present),
      .gap_qual     (gap_qual),
      .line_qual    (line_qual)
   );

   assign bump = !BMPL_n || !BMPR_n;

   always_comb begin
      state_d = state_q;
      plan_d  = plan_q;
      off_d   = off_q;
      clr_d   = 1'b0;
      case (state_q)
         IDLE, STOP: begin
            if (cmd_rdy) begin
               plan_d  = cmd;
               clr_d   = 1'b1;
               state_d = FOLLOW;
            end
         end
         FOLLOW: begin
            if (bump) begin
               state_d = STOP;
            end else if (gap_qual) begin
               plan_d = {2'b00, plan_q[15:2]};
               case (plan_q[1:0])
                  DIR_STOP: state_d = STOP;
                  DIR_RGHT: begin state_d = VEER; off_d = VEER_OFF;  end
                  DIR_LFT:  begin state_d = VEER; off_d = -VEER_OFF; end
                  DIR_TURN: begin state_d = TURN; off_d = TURN_OFF;  end
               endcase
            end
         end
         VEER: begin
            if (bump) begin
               state_d = STOP;
            end else if ((dwell_q >= VEER_THR) && line_qual) begin
               state_d = FOLLOW;
            end
         end
         TURN: begin
            if (bump) begin
               state_d = STOP;
            end else if ((dwell_q >= TURN_THR) && line_qual) begin
               state_d = FOLLOW;
            end
         end
         default: state_d = IDLE;
      endcase

      // Dwell restarts on any state entry and otherwise saturates.
      if (state_d != state_q) begin
         dwell_d = '0;
      end else begin
         dwell_d = (dwell_q == '1) ? dwell_q : dwell_q + 1'b1;
      end

      go_d   = (state_q == FOLLOW) || (state_q == VEER) || (state_q == TURN);
      err_d  = ((state_q == VEER) || (state_q == TURN)) ? off_q : 12'sd0;
      buzz_d = (state_q == STOP);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         plan_q  <= '0;
         off_q   <= '0;
         dwell_q <= '0;
         go_q    <= 1'b0;
         err_q   <= '0;
         buzz_q  <= 1'b0;
         clr_q   <= 1'b0;
         dbg_q   <= '0;
      end else begin
         state_q <= state_d;
         plan_q  <= plan_d;
         off_q   <= off_d;
         dwell_q <= dwell_d;
         go_q    <= go_d;
         err_q   <= err_d;
         buzz_q  <= buzz_d;
         clr_q   <= clr_d;
         dbg_q   <= state_q;
      end
   end

   assign go          = go_q;
   assign err_offset  = err_q;
   assign buzz_en     = buzz_q;
   assign clr_cmd_rdy = clr_q;
   assign state_dbg   = dbg_q;

endmodule

// File: tb/tb_maze_plan_ctrl.sv
// Bench for maze_plan_ctrl: directed scenarios plus randomized traffic against a plan-queue model.
module tb_maze_plan_ctrl;

   localparam int GAP  = 16;
   localparam int LINE = 8;
   localparam int VMIN = 100;
   localparam int TMIN = 200;

   localparam int S_IDLE   = 0;
   localparam int S_FOLLOW = 1;
   localparam int S_VEER   = 2;
   localparam int S_TURN   = 3;
   localparam int S_STOP   = 4;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [15:0]        cmd = '0;
   logic               cmd_rdy = 1'b0;
   logic               clr_cmd_rdy;
   logic               line_present = 1'b1;
   logic               BMPL_n = 1'b1;
   logic               BMPR_n = 1'b1;
   logic               go;
   logic signed [11:0] err_offset;
   logic               buzz_en;
   logic [2:0]         state_dbg;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   maze_plan_ctrl #(
      .GAP_CYC      (GAP),
      .LINE_CYC     (LINE),
      .VEER_MIN_CYC (VMIN),
      .TURN_MIN_CYC (TMIN)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd          (cmd),
      .cmd_rdy      (cmd_rdy),
      .clr_cmd_rdy  (clr_cmd_rdy),
      .line_present (line_present),
      .BMPL_n       (BMPL_n),
      .BMPR_n       (BMPR_n),
      .go           (go),
      .err_offset   (err_offset),
      .buzz_en      (buzz_en),
      .state_dbg    (state_dbg)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the plan is a queue of codes, the rest is run lengths and a dwell count.
   int m_st = S_IDLE;
   int m_abs = 0;
   int m_pre = 0;
   int m_dwell = 0;
   int m_off = 0;
   int codes[$];
   int e_go = 0, e_off = 0, e_buzz = 0, e_clr = 0, e_dbg = 0;

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_st = S_IDLE; m_abs = 0; m_pre = 0; m_dwell = 0; m_off = 0;
            codes.delete();
            e_go = 0; e_off = 0; e_buzz = 0; e_clr = 0; e_dbg = 0;
         end else begin
            int nst;
            int code;
            bit bump;
            e_go   = (m_st == S_FOLLOW || m_st == S_VEER || m_st == S_TURN) ? 1 : 0;
            e_buzz = (m_st == S_STOP) ? 1 : 0;
            e_off  = (m_st == S_VEER || m_st == S_TURN) ? m_off : 0;
            e_dbg  = m_st;
            e_clr  = 0;
            bump   = !BMPL_n || !BMPR_n;
            nst    = m_st;
            case (m_st)
               S_IDLE, S_STOP: begin
                  if (cmd_rdy) begin
                     codes.delete();
                     for (int i = 0; i < 8; i++) codes.push_back(int'((cmd >> (2 * i)) & 16'h3));
                     e_clr = 1;
                     nst = S_FOLLOW;
                  end
               end
               S_FOLLOW: begin
                  if (bump) nst = S_STOP;
                  else if (m_abs >= GAP) begin
                     code = (codes.size() > 0) ? codes.pop_front() : 0;
                     case (code)
                        0: nst = S_STOP;
                        1: begin nst = S_VEER; m_off = 400; end
                        2: begin nst = S_VEER; m_off = -400; end
                        default: begin nst = S_TURN; m_off = 1024; end
                     endcase
                  end
               end
               S_VEER: begin
                  if (bump) nst = S_STOP;
                  else if (m_dwell >= VMIN && m_pre >= LINE) nst = S_FOLLOW;
               end
               S_TURN: begin
                  if (bump) nst = S_STOP;
                  else if (m_dwell >= TMIN && m_pre >= LINE) nst = S_FOLLOW;
               end
               default: nst = S_IDLE;
            endcase
            m_dwell = (nst != m_st) ? 0 : m_dwell + 1;
            m_abs   = line_present ? 0 : m_abs + 1;
            m_pre   = line_present ? m_pre + 1 : 0;
            m_st    = nst;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            check("go", int'(go), e_go);
            check("err_offset", int'($signed(err_offset)), e_off);
            check("buzz_en", int'(buzz_en), e_buzz);
            check("clr_cmd_rdy", int'(clr_cmd_rdy), e_clr);
            check("state_dbg", int'(state_dbg), e_dbg);
         end
      end
   end

   task automatic drive(input logic lp, input int n);
      line_present = lp;
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic send_cmd(input logic [15:0] c);
      cmd = c;
      cmd_rdy = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #2;
         if (clr_cmd_rdy) break;
      end
      check("cmd_accept", int'(clr_cmd_rdy), 1);
      cmd_rdy = 1'b0;
   endtask

   initial begin
      #2_000_000;
      bad++;
      $display("FAIL watchdog: got timeout, expected finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      int run_left;
      logic lvl;
      repeat (3) @(posedge clk);
      #1;
      check("rst_go", int'(go), 0);
      check("rst_err", int'($signed(err_offset)), 0);
      check("rst_buzz", int'(buzz_en), 0);
      check("rst_clr", int'(clr_cmd_rdy), 0);
      check("rst_state", int'(state_dbg), S_IDLE);
      #1;
      rst_n = 1'b1;
      chk_en = 1'b1;
      drive(1'b1, 2);

      // Right veer, then exit once dwell and reacquire are both met.
      send_cmd(16'h0001);
      drive(1'b1, 2);
      check("a_go", int'(go), 1);
      drive(1'b0, 16);
      drive(1'b1, 1);
      check("a_err_early", int'($signed(err_offset)), 0);
      drive(1'b1, 1);
      check("a_err_right", int'($signed(err_offset)), 400);
      drive(1'b1, 100);
      check("a_err_hold", int'($signed(err_offset)), 400);
      drive(1'b1, 1);
      check("a_err_exit", int'($signed(err_offset)), 0);
      drive(1'b0, 16);
      drive(1'b1, 3);
      check("a_stop_buzz", int'(buzz_en), 1);

      // Left veer: reacquire early does not shorten the minimum dwell.
      send_cmd(16'h0002);
      drive(1'b1, 2);
      drive(1'b0, 16);
      drive(1'b0, 2);
      check("b_err_left", int'($signed(err_offset)), -400);
      drive(1'b0, 48);
      drive(1'b1, 40);
      check("b_err_min", int'($signed(err_offset)), -400);
      drive(1'b1, 60);
      check("b_err_exit", int'($signed(err_offset)), 0);
      drive(1'b0, 16);
      drive(1'b1, 3);

      // Turn around.
      send_cmd(16'h0003);
      drive(1'b1, 2);
      drive(1'b0, 16);
      drive(1'b1, 2);
      check("c_err_turn", int'($signed(err_offset)), 1024);
      drive(1'b1, 150);
      check("c_err_min", int'($signed(err_offset)), 1024);
      drive(1'b1, 60);
      check("c_err_exit", int'($signed(err_offset)), 0);
      drive(1'b0, 16);
      drive(1'b1, 3);
      check("c_go_stop", int'(go), 0);
      check("c_buzz", int'(buzz_en), 1);

      // Glitch one short of a gap, then a real gap on an empty plan.
      send_cmd(16'h0000);
      drive(1'b1, 4);
      drive(1'b0, 15);
      drive(1'b1, 5);
      check("d_go_glitch", int'(go), 1);
      check("d_state_glitch", int'(state_dbg), S_FOLLOW);
      drive(1'b0, 16);
      drive(1'b1, 3);
      check("d_go_stop", int'(go), 0);
      check("d_state_stop", int'(state_dbg), S_STOP);

      // Bump mid-veer, then a command that coincides with a held bump.
      send_cmd(16'hAAAA);
      drive(1'b1, 2);
      drive(1'b0, 16);
      drive(1'b1, 2);
      check("e_err_left", int'($signed(err_offset)), -400);
      drive(1'b1, 20);
      BMPL_n = 1'b0;
      drive(1'b1, 1);
      BMPL_n = 1'b1;
      drive(1'b1, 1);
      check("e_bump_go", int'(go), 0);
      check("e_bump_buzz", int'(buzz_en), 1);
      BMPL_n = 1'b0;
      send_cmd(16'hAAAA);
      drive(1'b1, 1);
      BMPL_n = 1'b1;
      drive(1'b1, 2);
      check("e_rebump_state", int'(state_dbg), S_STOP);
      send_cmd(16'hAAAA);
      drive(1'b1, 2);
      check("e_resume_go", int'(go), 1);
      BMPR_n = 1'b0;
      drive(1'b1, 1);
      BMPR_n = 1'b1;
      drive(1'b1, 2);

      // Eight right veers, then the drained plan stops on the ninth gap.
      send_cmd(16'h5555);
      drive(1'b1, 2);
      for (int g = 0; g < 8; g++) begin
         drive(1'b0, 16);
         drive(1'b1, 2);
         check("f_err_veer", int'($signed(err_offset)), 400);
         drive(1'b1, 110);
      end
      drive(1'b0, 16);
      drive(1'b1, 3);
      check("f_ninth_buzz", int'(buzz_en), 1);

      // Reset mid-veer takes effect without a clock edge.
      send_cmd(16'h5555);
      drive(1'b1, 2);
      drive(1'b0, 16);
      drive(1'b1, 10);
      rst_n = 1'b0;
      #1;
      check("r_go_async", int'(go), 0);
      check("r_state_async", int'(state_dbg), S_IDLE);
      check("r_err_async", int'($signed(err_offset)), 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(1'b0, 20);
      check("r_idle_go", int'(go), 0);
      check("r_idle_state", int'(state_dbg), S_IDLE);

      // Randomized traffic: line runs, sporadic bumps, commands in any state.
      run_left = 0;
      lvl = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         if (run_left == 0) begin
            lvl = 1'($urandom_range(0, 1));
            run_left = lvl ? $urandom_range(1, 150) : $urandom_range(1, 30);
         end
         run_left--;
         line_present = lvl;
         BMPL_n = ($urandom_range(0, 299) != 0);
         BMPR_n = ($urandom_range(0, 299) != 0);
         if (cmd_rdy && clr_cmd_rdy) cmd_rdy = 1'b0;
         else if (!cmd_rdy && $urandom_range(0, 39) == 0) begin
            cmd = 16'($urandom);
            cmd_rdy = 1'b1;
         end
         @(posedge clk);
         #2;
      end
      BMPL_n = 1'b1;
      BMPR_n = 1'b1;
      drive(1'b1, 3);
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
